// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the ALU issue stage.
//   opcode_e    : ALU opcode (ADD=0, SUB=1, AND=2, OR=3)
//   cmd_t       : packed {op,a,b} command as buffered in the command FIFO
//   res_state_e : result-stage state (R_EMPTY, R_HOLD)
package alu_pkg;
    localparam int ALU_W = 8;
    typedef enum logic [1:0] {ADD = 2'd0, SUB = 2'd1, AND = 2'd2, OR = 2'd3} opcode_e;
    typedef struct packed {
        opcode_e          op;
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
    } cmd_t;
    typedef enum logic {R_EMPTY = 1'b0, R_HOLD = 1'b1} res_state_e;
endpackage

// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if: command and result valid/ready channels of the issue stage.
//   cmd_valid/cmd_ready/cmd_op/cmd_a/cmd_b : command channel into the stage
//   res_valid/res_ready/res_y/res_op       : registered result channel out of the stage
//   res_zero                               : result-is-zero flag, only with ALU_ZERO_FLAG_EN
//   modport slave = the issue stage, modport master = the environment
interface alu_issue_stage_if #(parameter int W = alu_pkg::ALU_W);
    import alu_pkg::*;
    logic           cmd_valid;
    logic           cmd_ready;
    opcode_e        cmd_op;
    logic [W-1:0]   cmd_a;
    logic [W-1:0]   cmd_b;
    logic           res_valid;
    logic           res_ready;
    logic [W-1:0]   res_y;
    opcode_e        res_op;
`ifdef ALU_ZERO_FLAG_EN
    logic           res_zero;
    modport slave  (input cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
                    output cmd_ready, res_valid, res_y, res_op, res_zero);
    modport master (output cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
                    input cmd_ready, res_valid, res_y, res_op, res_zero);
`else
    modport slave  (input cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
                    output cmd_ready, res_valid, res_y, res_op);
    modport master (output cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
                    input cmd_ready, res_valid, res_y, res_op);
`endif
endinterface

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous DEPTH-entry FIFO of cmd_t commands.
//   clk, rst_n (sync, active-low), clr (sync clear)
//   push/din : write when push=1;  pop : drop head when pop=1
//   head     : head entry, all-zero (ADD,0,0) when empty
//   cnt/full/empty : occupancy
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       push,
    input  cmd_t                       din,
    input  logic                       pop,
    output cmd_t                       head,
    output logic [$clog2(DEPTH+1)-1:0] cnt,
    output logic                       full,
    output logic                       empty
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    cmd_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    assign full  = cnt == CW'(DEPTH);
    assign empty = cnt == '0;
    assign head  = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) mem[wr_ptr] <= din;
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr + PW'(pop);
            cnt    <= cnt + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: buffers {op,a,b} commands, drives the FIFO head onto the ALU and registers its result.
//   clk, rst_n (sync, active-low), flush (sync clear of FIFO and result)
//   bus      : alu_issue_stage_if.slave, command in / result out over valid/ready
//   alu_op/alu_a/alu_b : FIFO head to the ALU (ADD,0,0 when empty);  alu_y : combinational ALU result
//   fifo_cnt : FIFO occupancy
//   ALU_ZERO_FLAG_EN : adds bus.res_zero, registered alongside res_y as (alu_y==0)
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = ALU_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    alu_issue_stage_if.slave           bus,
    output opcode_e                    alu_op,
    output logic [W-1:0]               alu_a,
    output logic [W-1:0]               alu_b,
    input  logic [W-1:0]               alu_y,
    output logic [$clog2(DEPTH+1)-1:0] fifo_cnt
);
    cmd_t       cmd_in;
    cmd_t       head;
    logic       full;
    logic       empty;
    logic       push;
    logic       issue;
    res_state_e state_q;
    res_state_e state_d;
    logic [W-1:0] res_y_q;
    opcode_e      res_op_q;

    assign cmd_in        = '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b};
    // full blocks acceptance even when the head is popped this cycle
    assign bus.cmd_ready = rst_n && !flush && !full;
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign issue         = !empty && (state_q == R_EMPTY || bus.res_ready);
    assign alu_op        = head.op;
    assign alu_a         = head.a;
    assign alu_b         = head.b;
    assign bus.res_y     = res_y_q;
    assign bus.res_op    = res_op_q;

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .push  (push),
        .din   (cmd_in),
        .pop   (issue),
        .head  (head),
        .cnt   (fifo_cnt),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_d       = issue ? R_HOLD : (bus.res_ready ? R_EMPTY : state_q);
        bus.res_valid = state_q == R_HOLD;
    end

`ifdef ALU_ZERO_FLAG_EN
    logic res_zero_q;
    assign bus.res_zero = res_zero_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            state_q  <= R_EMPTY;
            res_y_q  <= '0;
            res_op_q <= ADD;
`ifdef ALU_ZERO_FLAG_EN
            res_zero_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (issue) begin
                res_y_q  <= alu_y;
                res_op_q <= head.op;
`ifdef ALU_ZERO_FLAG_EN
                res_zero_q <= alu_y == '0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: randomized and directed checks of alu_issue_stage against a queue-based model.
module tb_alu_issue_stage;
    import alu_pkg::*;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    opcode_e    alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_y;
    logic [2:0] fifo_cnt;

    always #5 clk = ~clk;

    alu_issue_stage_if bus ();

    alu_issue_stage #(.DEPTH(DEPTH), .W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .bus      (bus),
        .alu_op   (alu_op),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_y    (alu_y),
        .fifo_cnt (fifo_cnt)
    );

    function automatic logic [7:0] ref_alu(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    assign alu_y = ref_alu(alu_op, alu_a, alu_b);

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } mcmd_t;

    mcmd_t      q[$];
    logic       hv = 1'b0;
    logic [7:0] hy = 8'h00;
    logic [1:0] hop = 2'd0;
    bit         chk_en = 1'b0;
    int         n_tests = 0;
    int         n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        mcmd_t c;
        bit    rdy;
        bit    iss;
        if (!rst_n || flush) begin
            q.delete();
            hv = 1'b0;
        end else begin
            rdy = q.size() < DEPTH;
            iss = q.size() != 0 && (!hv || bus.res_ready);
            if (iss) begin
                c   = q.pop_front();
                hv  = 1'b1;
                hy  = ref_alu(c.op, c.a, c.b);
                hop = c.op;
            end else if (hv && bus.res_ready) begin
                hv = 1'b0;
            end
            if (bus.cmd_valid && rdy) q.push_back('{bus.cmd_op, bus.cmd_a, bus.cmd_b});
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmd_ready", bus.cmd_ready, rst_n && !flush && q.size() < DEPTH);
            chk("fifo_cnt", fifo_cnt, q.size());
            chk("res_valid", bus.res_valid, hv);
            chk("alu_op", alu_op, q.size() != 0 ? q[0].op : 2'd0);
            chk("alu_a", alu_a, q.size() != 0 ? q[0].a : 8'h00);
            chk("alu_b", alu_b, q.size() != 0 ? q[0].b : 8'h00);
            if (hv) begin
                chk("res_y", bus.res_y, hy);
                chk("res_op", bus.res_op, hop);
`ifdef ALU_ZERO_FLAG_EN
                chk("res_zero", bus.res_zero, hy == 8'h00);
`endif
            end
        end
    end

    task automatic drive(input bit v, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.cmd_valid = v;
        bus.cmd_op    = opcode_e'(op);
        bus.cmd_a     = a;
        bus.cmd_b     = b;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] bp_op [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [7:0] bp_a  [5] = '{8'h10, 8'h10, 8'hF0, 8'h0F, 8'h80};
    logic [7:0] bp_b  [5] = '{8'h01, 8'h03, 8'h3C, 8'h30, 8'h80};
    logic [7:0] bp_y  [5] = '{8'h11, 8'h0D, 8'h30, 8'h3F, 8'h00};

    initial begin
        drive(1'b1, 2'd0, 8'h01, 8'h02);
        bus.res_ready = 1'b0;
        cyc();
        chk_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_cmd_ready", bus.cmd_ready, 0);
            chk("rst_res_valid", bus.res_valid, 0);
            chk("rst_fifo_cnt", fifo_cnt, 0);
            cyc();
        end
        chk("rst_res_y", bus.res_y, 0);
        chk("rst_res_op", bus.res_op, 0);
        rst_n = 1'b1;
        drive(1'b0, 2'd0, 8'h00, 8'h00);
        @(negedge clk);
        chk("rel_cmd_ready", bus.cmd_ready, 1);
        cyc();

        drive(1'b1, 2'd0, 8'h12, 8'h34);
        bus.res_ready = 1'b1;
        cyc();
        drive(1'b0, 2'd0, 8'h00, 8'h00);
        @(negedge clk);
        chk("lat_valid_early", bus.res_valid, 0);
        chk("lat_cnt", fifo_cnt, 1);
        chk("lat_alu_a", alu_a, 8'h12);
        cyc();
        @(negedge clk);
        chk("lat_valid", bus.res_valid, 1);
        chk("lat_res_y", bus.res_y, 8'h46);
        chk("lat_res_op", bus.res_op, 0);
        cyc();

        drive(1'b1, 2'd0, 8'hFF, 8'h01);
        cyc();
        drive(1'b1, 2'd1, 8'h00, 8'h01);
        cyc();
        drive(1'b0, 2'd0, 8'h00, 8'h00);
        @(negedge clk);
        chk("wrap_add", bus.res_y, 8'h00);
`ifdef ALU_ZERO_FLAG_EN
        chk("wrap_add_zero", bus.res_zero, 1);
`endif
        cyc();
        @(negedge clk);
        chk("wrap_sub", bus.res_y, 8'hFF);
        chk("wrap_sub_op", bus.res_op, 1);
`ifdef ALU_ZERO_FLAG_EN
        chk("wrap_sub_zero", bus.res_zero, 0);
`endif
        cyc();
        cyc();

        bus.res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, bp_op[i], bp_a[i], bp_b[i]);
            @(negedge clk);
            chk("bp_ready", bus.cmd_ready, 1);
            cyc();
        end
        drive(1'b1, 2'd0, 8'h55, 8'h55);
        @(negedge clk);
        chk("bp_full_ready", bus.cmd_ready, 0);
        chk("bp_full_cnt", fifo_cnt, 4);
        chk("bp_held", bus.res_valid, 1);
        chk("bp_held_y", bus.res_y, bp_y[0]);
        cyc();
        drive(1'b0, 2'd0, 8'h00, 8'h00);
        bus.res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) chk("bp_full_pop_ready", bus.cmd_ready, 0);
            chk("bp_res_valid", bus.res_valid, 1);
            chk("bp_res_y", bus.res_y, bp_y[i]);
            chk("bp_res_op", bus.res_op, bp_op[i]);
            cyc();
        end
        @(negedge clk);
        chk("bp_drained", bus.res_valid, 0);
        cyc();

        bus.res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'(i), 8'(i), 8'h01);
            cyc();
        end
        drive(1'b1, 2'd0, 8'hAA, 8'hBB);
        flush = 1'b1;
        @(negedge clk);
        chk("fl_ready", bus.cmd_ready, 0);
        chk("fl_cnt_before", fifo_cnt, 3);
        chk("fl_held_before", bus.res_valid, 1);
        cyc();
        flush = 1'b0;
        drive(1'b0, 2'd0, 8'h00, 8'h00);
        @(negedge clk);
        chk("fl_cnt", fifo_cnt, 0);
        chk("fl_valid", bus.res_valid, 0);
        cyc();

        bus.res_ready = 1'b1;
        repeat (20) begin
            drive(1'b1, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
            @(negedge clk);
            chk("stream_cnt_le1", fifo_cnt <= 3'd1, 1);
            cyc();
        end
        drive(1'b0, 2'd0, 8'h00, 8'h00);
        repeat (3) cyc();

        bus.res_ready = 1'b0;
        repeat (4) begin
            drive(1'b1, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
            cyc();
        end
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        drive(1'b0, 2'd0, 8'h00, 8'h00);
        @(negedge clk);
        chk("midrst_cnt", fifo_cnt, 0);
        chk("midrst_valid", bus.res_valid, 0);
        cyc();

        repeat (400) begin
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
            bus.res_ready = $urandom_range(0, 2) != 0;
            flush = $urandom_range(0, 31) == 0;
            rst_n = $urandom_range(0, 63) != 0;
            cyc();
        end
        rst_n = 1'b1;
        flush = 1'b0;
        bus.res_ready = 1'b1;
        drive(1'b0, 2'd0, 8'h00, 8'h00);
        repeat (8) cyc();
        @(negedge clk);
        chk("end_idle_cnt", fifo_cnt, 0);
        chk("end_idle_valid", bus.res_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
